// File: rtl/tpu_pkg.sv
// tpu_pkg: shared weight-path constants, weight word type and feeder FSM states
package tpu_pkg;
   localparam int WEIGHT_WIDTH = 16;
   localparam int WEIGHT_PIXEL_NUM = 8;
   localparam int SRAM_DEPTH = 16;
   localparam int SRAM_ADDR_W = 6;
   typedef logic [WEIGHT_WIDTH*WEIGHT_PIXEL_NUM-1:0] w_t;
   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
endpackage

// File: rtl/weight_skid_fifo.sv
// weight_skid_fifo: 2-entry buffer of {last, data} words, flushed by srst
module weight_skid_fifo
   import tpu_pkg::*;
#(
   parameter int DW = $bits(w_t)
) (
   input  logic          clk,
   input  logic          srst,
   input  logic          push,
   input  logic [DW-1:0] din,
   input  logic          last_in,
   input  logic          pop,
   output logic [1:0]    count,
   output logic [DW-1:0] head_data,
   output logic          head_last
);
   logic [DW:0] mem [2];
   logic wp, rp;
   assign {head_last, head_data} = mem[rp];
   always_ff @(posedge clk) begin
      if (srst) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wp <= 1'b0;
         rp <= 1'b0;
         count <= 2'd0;
      end else begin
         if (push) mem[wp] <= {last_in, din};
         wp <= wp ^ push;
         rp <= rp ^ pop;
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end
endmodule

// File: rtl/weight_feeder.sv
// weight_feeder: streams a run of weight SRAM words to the systolic array.
// Optional WEIGHT_FEEDER_STALL_CNT_EN adds a saturating downstream stall counter.
module weight_feeder
   import tpu_pkg::*;
#(
   parameter int WEIGHT_WIDTH = tpu_pkg::WEIGHT_WIDTH,
   parameter int WEIGHT_PIXEL_NUM = tpu_pkg::WEIGHT_PIXEL_NUM,
   parameter int SRAM_DEPTH = tpu_pkg::SRAM_DEPTH
) (
   input  logic                                   clk,
   input  logic                                   srst,
   input  logic                                   start,
   input  logic [5:0]                             base_addr,
   input  logic [4:0]                             len,
   output logic                                   busy,
   output logic                                   done,
   output logic                                   sram_csb,
   output logic                                   sram_wsb,
   output logic [SRAM_ADDR_W-1:0]                 sram_raddr,
   input  logic [WEIGHT_WIDTH*WEIGHT_PIXEL_NUM-1:0] sram_rdata,
   output logic                                   w_valid,
   input  logic                                   w_ready,
   output logic [WEIGHT_WIDTH*WEIGHT_PIXEL_NUM-1:0] w_data,
   output logic                                   w_last
`ifdef WEIGHT_FEEDER_STALL_CNT_EN
   ,output logic [15:0]                           stall_cnt
`endif
);
   localparam int DW = WEIGHT_WIDTH*WEIGHT_PIXEL_NUM;
   localparam int AW = $clog2(SRAM_DEPTH);
   state_t state;
   logic [AW-1:0] addr;
   logic [4:0] len_q, iss_cnt, ret_cnt;
   logic [1:0] count;
   logic pend, rd, pop;
   logic unused_base;
   assign unused_base = ^base_addr[5:AW];
   assign pop = w_valid & w_ready;
   // credit: buffered + returning - leaving must leave room for this read's data
   assign rd = state == FETCH && !srst && ({1'b0, count} + {2'b00, pend} - {2'b00, pop}) < 3'd2;
   assign sram_csb = ~rd;
   assign sram_wsb = 1'b1;
   assign sram_raddr = {{(SRAM_ADDR_W-AW){1'b0}}, addr};
   assign busy = state != IDLE;
   assign w_valid = count != 2'd0;
   weight_skid_fifo #(.DW(DW)) u_fifo (
      .clk(clk),
      .srst(srst),
      .push(pend),
      .din(sram_rdata),
      .last_in(ret_cnt == len_q - 5'd1),
      .pop(pop),
      .count(count),
      .head_data(w_data),
      .head_last(w_last)
   );
   always_ff @(posedge clk) begin
      if (srst) begin
         state <= IDLE;
         addr <= '0;
         len_q <= '0;
         iss_cnt <= '0;
         ret_cnt <= '0;
         pend <= 1'b0;
         done <= 1'b0;
      end else begin
         done <= 1'b0;
         pend <= rd;
         if (pend) ret_cnt <= ret_cnt + 5'd1;
         if (rd) begin
            addr <= addr + 1'b1;
            iss_cnt <= iss_cnt + 5'd1;
         end
         case (state)
            IDLE: if (start) begin
               if (len == 5'd0) done <= 1'b1;
               else begin
                  state <= FETCH;
                  addr <= base_addr[AW-1:0];
                  len_q <= len;
                  iss_cnt <= '0;
                  ret_cnt <= '0;
               end
            end
            FETCH: if (rd && iss_cnt + 5'd1 == len_q) state <= DRAIN;
            DRAIN: if (pop && w_last) begin
               state <= IDLE;
               done <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
`ifdef WEIGHT_FEEDER_STALL_CNT_EN
   always_ff @(posedge clk) begin
      if (srst || (!busy && start)) stall_cnt <= '0;
      else if (busy && w_valid && !w_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
   end
`endif
endmodule

// File: tb/tb_weight_feeder.sv
// tb_weight_feeder: scoreboard bench for weight_feeder; expected words queued at start, popped by a monitor
module tb_weight_feeder;
   logic clk = 0, srst = 1, start = 0, w_ready = 1;
   logic [5:0] base_addr = 0;
   logic [4:0] len = 0;
   logic busy, done, sram_csb, sram_wsb, w_valid, w_last;
   logic [5:0] sram_raddr;
   logic [127:0] sram_rdata = '0, w_data;
`ifdef WEIGHT_FEEDER_STALL_CNT_EN
   logic [15:0] stall_cnt;
`endif
   logic [127:0] mem [16];
   logic [128:0] sb [$];
   int addr_q [$], addr_rel [$];
   int checks = 0, errors = 0, cyc = 0, c0 = 0;
   int issued, popped, max_out, first_valid_rel, last_rel, done_rel;
   bit done_seen, busy_seen, stalled_prev, srst_prev;
   logic [127:0] prev_data;

   weight_feeder dut (
      .clk(clk), .srst(srst), .start(start), .base_addr(base_addr), .len(len),
      .busy(busy), .done(done), .sram_csb(sram_csb), .sram_wsb(sram_wsb),
      .sram_raddr(sram_raddr), .sram_rdata(sram_rdata), .w_valid(w_valid),
      .w_ready(w_ready), .w_data(w_data), .w_last(w_last)
`ifdef WEIGHT_FEEDER_STALL_CNT_EN
      , .stall_cnt(stall_cnt)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (!sram_csb) sram_rdata <= mem[sram_raddr[3:0]];

   task automatic chk(input string nm, input logic [128:0] act, input logic [128:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      int rel;
      logic [128:0] e;
      rel = cyc - c0 + 1;
      if (busy) busy_seen = 1;
      if (!sram_csb) begin
         addr_q.push_back(int'(sram_raddr));
         addr_rel.push_back(rel);
         issued++;
      end
      if (w_valid && first_valid_rel == 0) first_valid_rel = rel;
      if (w_valid && w_ready) begin
         popped++;
         if (w_last) last_rel = rel;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got %0h expected none", w_data);
         end else begin
            e = sb.pop_front();
            chk("w_data", {1'b0, w_data}, {1'b0, e[127:0]});
            chk("w_last", {128'd0, w_last}, {128'd0, e[128]});
         end
      end
      if (stalled_prev && !srst_prev) chk("stall_hold", {w_valid, w_data}, {1'b1, prev_data});
      stalled_prev = w_valid && !w_ready;
      srst_prev = srst;
      prev_data = w_data;
      if (issued - popped > max_out) max_out = issued - popped;
      if (done) begin
         done_seen = 1;
         done_rel = rel;
      end
   end

   task automatic go(input int b, input int l);
      @(posedge clk); #1;
      base_addr = 6'(b); len = 5'(l); start = 1;
      addr_q.delete(); addr_rel.delete();
      issued = 0; popped = 0; max_out = 0; first_valid_rel = 0; last_rel = 0;
      done_rel = 0; done_seen = 0; busy_seen = 0;
      for (int i = 0; i < l; i++) sb.push_back({i == l - 1, mem[(b + i) % 16]});
      @(posedge clk); #1;
      start = 0; c0 = cyc;
   endtask

   task automatic wait_done();
      int n = 0;
      while (!done_seen && n < 80) begin
         @(posedge clk); #1;
         n++;
      end
      chk("done_seen", {128'd0, done_seen}, 129'd1);
      @(negedge clk);
      @(negedge clk);
      chk("done_pulse_low", {128'd0, done}, 129'd0);
      chk("sb_empty", 129'(sb.size()), 129'd0);
   endtask

   task automatic chk_addrs(input int b, input int n, input bit timed);
      chk("n_reads", 129'(addr_q.size()), 129'(n));
      for (int i = 0; i < n && i < addr_q.size(); i++) begin
         chk("raddr", 129'(addr_q[i]), 129'((b + i) % 16));
         if (timed) chk("raddr_cycle", 129'(addr_rel[i]), 129'(i + 1));
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++)
         for (int k = 0; k < 8; k++) mem[i][16*k +: 16] = {i[3:0], k[3:0], 8'hA5};
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", {busy, done, sram_csb, sram_wsb, sram_raddr, w_valid, w_last, 119'd0},
          {1'b0, 1'b0, 1'b1, 1'b1, 6'd0, 1'b0, 1'b0, 119'd0});
      chk("reset_w_data", {1'b0, w_data}, 129'd0);
      @(posedge clk); #1 srst = 0;

      go(3, 4);
      wait_done();
      chk_addrs(3, 4, 1);
      chk("first_valid_cycle", 129'(first_valid_rel), 129'd3);
      chk("last_cycle", 129'(last_rel), 129'd6);
      chk("done_cycle", 129'(done_rel), 129'd7);

      go(14, 4);
      wait_done();
      chk_addrs(14, 4, 1);

      go(2, 8);
      for (int k = 1; k <= 20; k++) begin
         w_ready = !(k >= 3 && k <= 7);
         @(posedge clk); #1;
      end
      wait_done();
      chk_addrs(2, 8, 0);
      chk("max_outstanding", 129'(max_out), 129'd2);
`ifdef WEIGHT_FEEDER_STALL_CNT_EN
      chk("stall_cnt", 129'(stall_cnt), 129'd5);
`endif

      go(5, 0);
      wait_done();
      chk("len0_done_cycle", 129'(done_rel), 129'd1);
      chk("len0_reads", 129'(addr_q.size()), 129'd0);
      chk("len0_busy", {128'd0, busy_seen}, 129'd0);

      go(0, 5);
      @(posedge clk); #1;
      base_addr = 9; len = 2; start = 1;
      @(posedge clk); #1 start = 0;
      wait_done();
      chk_addrs(0, 5, 1);
      chk("restart_done_cycle", 129'(done_rel), 129'd8);
      repeat (5) @(posedge clk);
      chk("no_second_run", 129'(addr_q.size()), 129'd5);

      w_ready = 0;
      go(0, 16);
      repeat (3) begin
         @(posedge clk); #1;
      end
      srst = 1;
      @(negedge clk);
      chk("srst_csb", {128'd0, sram_csb}, 129'd1);
      @(posedge clk); #1 srst = 0;
      @(negedge clk);
      chk("post_srst_outputs", {busy, done, sram_csb, sram_wsb, sram_raddr, w_valid, w_last, 119'd0},
          {1'b0, 1'b0, 1'b1, 1'b1, 6'd0, 1'b0, 1'b0, 119'd0});
      chk("post_srst_w_data", {1'b0, w_data}, 129'd0);
      sb.delete();
      w_ready = 1;
      go(7, 3);
      wait_done();
      chk_addrs(7, 3, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
